// File: rtl/riscv_pipe_pkg.sv
// rtl/riscv_pipe_pkg.sv - shared pipeline constants, encodings and EX/MEM payload
package riscv_pipe_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  // Occupancy of the two-entry skid buffer between EX and MEM
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

  // Everything MEM/WB needs from an executed instruction
  typedef struct packed {
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] store_data;
    logic [REGW-1:0] rd;
    logic            memtoreg;
    logic            we;
    logic            reg_en;
  } ex_mem_t;

  localparam int EX_MEM_W = $bits(ex_mem_t);

endpackage

// File: rtl/skid_buffer.sv
// rtl/skid_buffer.sv - two-entry valid/ready skid buffer with registered in_ready
module skid_buffer
  import riscv_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_t   state_q, state_d;
  logic [W-1:0] main_q, skid_q;
  logic         acc, drn;
  logic         load_main_in, load_main_skid, load_skid;

  // Handshake flags decode only the state register, so out_ready never reaches in_ready
  assign in_ready  = (state_q != BUF_FULL);
  assign out_valid = (state_q != BUF_EMPTY);
  assign out_data  = main_q;
  assign acc       = in_valid & in_ready;
  assign drn       = out_valid & out_ready;

  // Next occupancy and which entry moves where; flush drops everything held and arriving
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      BUF_EMPTY: begin
        if (acc) begin
          state_d      = BUF_ONE;
          load_main_in = 1'b1;
        end
      end
      BUF_ONE: begin
        if (acc && drn) begin
          load_main_in = 1'b1;
        end else if (acc) begin
          state_d   = BUF_FULL;
          load_skid = 1'b1;
        end else if (drn) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (drn) begin
          state_d        = BUF_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    if (flush) begin
      state_d        = BUF_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // State and payload registers; main holds the head so outputs stay put during a stall
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= BUF_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load_main_in) begin
        main_q <= in_data;
      end else if (load_main_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ALU, branch resolve, skid-buffered hand-off to MEM
module ex_stage
  import riscv_pipe_pkg::ex_mem_t;
  import riscv_pipe_pkg::EX_MEM_W;
  import riscv_pipe_pkg::ALU_SUB;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush_in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] data_in_1,
  input  logic [XLEN-1:0] data_in_2,
  input  logic [XLEN-1:0] imm_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [REGW-1:0] rd_in,
  input  logic            pcsrc_in,
  input  logic            alusrc_in,
  input  logic            aluop_in,
  input  logic            memtoreg_in,
  input  logic            we_in,
  input  logic            reg_en_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] store_data_out,
  output logic [REGW-1:0] rd_out,
  output logic            memtoreg_out,
  output logic            we_out,
  output logic            reg_en_out,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_target
);

  logic [XLEN-1:0] op_b, alu_res;
  logic            acc, taken, do_redirect;
  ex_mem_t         payload, head;
  logic [EX_MEM_W-1:0] head_bits;

  assign acc         = in_valid & in_ready;
  assign op_b        = alusrc_in ? imm_in : data_in_2;
  assign alu_res     = (aluop_in == ALU_SUB) ? (data_in_1 - op_b) : (data_in_1 + op_b);
  // Branch compare always uses rs1/rs2, regardless of which operand feeds the ALU
  assign taken       = pcsrc_in & (data_in_1 == data_in_2);
  assign do_redirect = acc & taken & ~flush_in;

  assign payload.alu_result = alu_res;
  assign payload.store_data = data_in_2;
  assign payload.rd         = rd_in;
  assign payload.memtoreg   = memtoreg_in;
  assign payload.we         = we_in;
  assign payload.reg_en     = reg_en_in;

  skid_buffer #(.W(EX_MEM_W)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (payload),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (head_bits)
  );

  assign head           = ex_mem_t'(head_bits);
  assign alu_result_out = head.alu_result;
  assign store_data_out = head.store_data;
  assign rd_out         = head.rd;
  assign memtoreg_out   = head.memtoreg;
  assign we_out         = head.we;
  assign reg_en_out     = head.reg_en;

  // Single-cycle redirect pulse; the target is kept after the pulse for debug visibility
  always_ff @(posedge clock) begin
    if (!reset) begin
      redirect_valid  <= 1'b0;
      redirect_target <= '0;
    end else begin
      redirect_valid <= do_redirect;
      if (do_redirect) begin
        redirect_target <= pc_in + imm_in;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - scoreboard bench for ex_stage with a behavioural reference model
module tb_ex_stage;

  logic        clock = 1'b0;
  logic        reset, flush_in, in_valid, in_ready;
  logic [31:0] data_in_1, data_in_2, imm_in, pc_in;
  logic [4:0]  rd_in;
  logic        pcsrc_in, alusrc_in, aluop_in, memtoreg_in, we_in, reg_en_in;
  logic        out_valid, out_ready;
  logic [31:0] alu_result_out, store_data_out;
  logic [4:0]  rd_out;
  logic        memtoreg_out, we_out, reg_en_out, redirect_valid;
  logic [31:0] redirect_target;

  ex_stage dut (
    .clock(clock), .reset(reset), .flush_in(flush_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .data_in_1(data_in_1), .data_in_2(data_in_2), .imm_in(imm_in), .pc_in(pc_in),
    .rd_in(rd_in), .pcsrc_in(pcsrc_in), .alusrc_in(alusrc_in), .aluop_in(aluop_in),
    .memtoreg_in(memtoreg_in), .we_in(we_in), .reg_en_in(reg_en_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_result_out(alu_result_out), .store_data_out(store_data_out), .rd_out(rd_out),
    .memtoreg_out(memtoreg_out), .we_out(we_out), .reg_en_out(reg_en_out),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic        mr, we, re;
  } exp_t;

  exp_t        sb[$];
  exp_t        pend_e;
  logic        pend_push = 1'b0, pend_redir = 1'b0;
  logic [31:0] pend_tgt = '0;
  logic        red_v = 1'b0;
  logic [31:0] red_t = '0;
  logic        mon_en = 1'b0;
  int          tests = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, b, im, input logic [4:0] rd,
                                 input logic asrc, aop, mr, we, re);
    exp_t e;
    logic [31:0] opb;
    opb   = asrc ? im : b;
    e.res = aop ? a - opb : a + opb;
    e.sd  = b;
    e.rd  = rd;
    e.mr  = mr;
    e.we  = we;
    e.re  = re;
    return e;
  endfunction

  // Model update at each active edge, using the expectation staged by the stimulus
  always @(posedge clock) begin
    if (!reset) begin
      sb.delete();
      red_v = 1'b0;
      red_t = '0;
    end else if (flush_in) begin
      sb.delete();
      red_v = 1'b0;
    end else begin
      if (pend_push) sb.push_back(pend_e);
      red_v = pend_redir;
      if (pend_redir) red_t = pend_tgt;
    end
  end

  // Monitor: compare DUT against the model mid-cycle, pop the head on a drain
  always @(negedge clock) begin
    if (mon_en) begin
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      chk("in_ready", 32'(in_ready), 32'(sb.size() < 2));
      chk("redirect_valid", 32'(redirect_valid), 32'(red_v));
      chk("redirect_target", redirect_target, red_t);
      if (out_valid && sb.size() != 0) begin
        chk("alu_result", alu_result_out, sb[0].res);
        chk("store_data", store_data_out, sb[0].sd);
        chk("ctrl", {24'd0, 3'd0, rd_out, memtoreg_out, we_out, reg_en_out},
            {24'd0, 3'd0, sb[0].rd, sb[0].mr, sb[0].we, sb[0].re});
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  // Drive one cycle of inputs and stage the model's expectation for the coming edge
  task automatic drive(input logic v, input logic [31:0] a, b, im, pc, input logic [4:0] rd,
                       input logic br, asrc, aop, fl, ordy, output logic accepted);
    logic raw_acc;
    in_valid = v; data_in_1 = a; data_in_2 = b; imm_in = im; pc_in = pc; rd_in = rd;
    pcsrc_in = br; alusrc_in = asrc; aluop_in = aop; flush_in = fl; out_ready = ordy;
    memtoreg_in = 1'($urandom); we_in = 1'($urandom); reg_en_in = 1'($urandom);
    raw_acc    = v && (sb.size() < 2);
    accepted   = raw_acc && !fl && reset;
    pend_push  = accepted;
    pend_e     = model(a, b, im, rd, asrc, aop, memtoreg_in, we_in, reg_en_in);
    pend_redir = raw_acc && br && (a == b) && !fl;
    pend_tgt   = pc + im;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    drive(1'b0, $urandom, $urandom, $urandom, $urandom, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ordy, acc);
  endtask

  task automatic send(input logic [31:0] a, b, im, pc, input logic [4:0] rd,
                      input logic br, asrc, aop, ordy);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 20) begin
      drive(1'b1, a, b, im, pc, rd, br, asrc, aop, 1'b0, ordy, acc);
      n++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    reset = 1'b0;
    drive(1'b1, 32'd5, 32'd5, 32'd3, 32'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst_alu", alu_result_out, 32'd0);
    chk("rst_store", store_data_out, 32'd0);
    chk("rst_ctrl", {rd_out, memtoreg_out, we_out, reg_en_out}, 32'd0);
    chk("rst_target", redirect_target, 32'd0);
    reset  = 1'b1;
    mon_en = 1'b1;
    idle(1'b1);

    send(32'd7, 32'd1, 32'd3, 32'h40, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("add_imm", alu_result_out, 32'd10);
    send(32'd7, 32'd9, 32'd0, 32'h44, 5'd2, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("sub_reg", alu_result_out, 32'hFFFF_FFFE);

    send(32'd4, 32'd4, 32'hFFFF_FFF0, 32'h100, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("br_taken_pulse", 32'(redirect_valid), 32'd1);
    chk("br_taken_target", redirect_target, 32'h0000_00F0);
    send(32'd4, 32'd5, 32'hFFFF_FFF0, 32'h100, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("br_not_taken", 32'(redirect_valid), 32'd0);
    idle(1'b1);

    send(32'd100, 32'd0, 32'd1, 32'h0, 5'd10, 1'b0, 1'b1, 1'b0, 1'b0);
    send(32'd200, 32'd0, 32'd2, 32'h0, 5'd11, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_head_is_a", alu_result_out, 32'd101);
    drive(1'b1, 32'd300, 32'd0, 32'd3, 32'h0, 5'd12, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, acc);
    chk("bp_c_rejected", 32'(acc), 32'd0);
    chk("bp_head_held", alu_result_out, 32'd101);
    send(32'd300, 32'd0, 32'd3, 32'h0, 5'd12, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (4) idle(1'b1);

    send(32'd1, 32'd0, 32'd1, 32'h0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    send(32'd2, 32'd0, 32'd1, 32'h0, 5'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'd8, 32'd8, 32'd16, 32'h200, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    chk("flush_full_valid", 32'(out_valid), 32'd0);
    chk("flush_full_ready", 32'(in_ready), 32'd1);
    chk("flush_full_redir", 32'(redirect_valid), 32'd0);
    send(32'd1, 32'd0, 32'd1, 32'h0, 5'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'd8, 32'd8, 32'd16, 32'h200, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    chk("flush_one_redir", 32'(redirect_valid), 32'd0);
    chk("flush_one_valid", 32'(out_valid), 32'd0);

    send(32'hFFFF_FFFF, 32'd0, 32'd1, 32'h0, 5'd4, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("wrap_alu", alu_result_out, 32'd0);
    send(32'd6, 32'd6, 32'd8, 32'hFFFF_FFFC, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("wrap_target", redirect_target, 32'd4);
    idle(1'b1);

    for (int i = 0; i < 500; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? a : $urandom;
      reset = ($urandom_range(0, 63) != 0);
      drive($urandom_range(0, 3) != 0, a, b, $urandom, $urandom, 5'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 15) == 0,
            $urandom_range(0, 2) != 0, acc);
      reset = 1'b1;
    end

    repeat (5) idle(1'b1);
    chk("final_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage sitting directly downstream of the ID/EX pipeline register; consumes its decoded operands and control bits.
- Computes the ALU result, resolves BEQ-style branches and issues a PC redirect.
- Presents results to the MEM stage through a 2-entry valid/ready skid buffer, so stalls from MEM never create a combinational path back to ID.

Parameters:
- XLEN, 32, datapath width.
- REGW, 5, destination register index width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (reset==0 resets on the clock edge)
- flush_in  in  1  hazard-unit flush; discards all held entries
- in_valid  in  1  ID/EX holds a valid instruction
- in_ready  out  1  stage can accept this cycle
- data_in_1  in  XLEN  rs1 value
- data_in_2  in  XLEN  rs2 value (ALU operand B or store data)
- imm_in  in  XLEN  sign-extended immediate
- pc_in  in  XLEN  instruction PC
- rd_in  in  REGW  destination register
- pcsrc_in  in  1  instruction is a conditional branch
- alusrc_in  in  1  1: operand B = imm_in; 0: operand B = data_in_2
- aluop_in  in  1  0: add; 1: subtract
- memtoreg_in, we_in, reg_en_in  in  1 each  control bits passed to MEM/WB
- out_valid  out  1  head entry valid toward MEM
- out_ready  in  1  MEM accepts head entry
- alu_result_out  out  XLEN  registered ALU result
- store_data_out  out  XLEN  registered data_in_2
- rd_out  out  REGW  registered rd
- memtoreg_out, we_out, reg_en_out  out  1 each  registered control bits
- redirect_valid  out  1  one-cycle pulse: branch taken
- redirect_target  out  XLEN  branch target PC

Behaviour:
- Accept: acc = in_valid & in_ready.
- Drain: drn = out_valid & out_ready.
- Arithmetic:
  - opB = alusrc_in ? imm_in : data_in_2.
  - result = aluop_in ? data_in_1 - opB : data_in_1 + opB, modulo 2^XLEN; no overflow flag.
- Branch resolution:
  - taken = pcsrc_in & (data_in_1 == data_in_2), independent of alusrc/aluop.
  - On acc & taken & ~flush_in: next cycle redirect_valid=1 and redirect_target = pc_in + imm_in (wraps mod 2^XLEN).
  - Otherwise redirect_valid=0; redirect_target holds its last value.
  - Branch entries still propagate downstream with their control bits unchanged.
- Buffer: main entry (drives outputs) plus skid entry.
  - State EMPTY (neither valid): acc -> ONE, loading main.
  - State ONE (main valid):
    - acc & drn -> ONE, main reloaded.
    - acc & ~drn -> FULL, new entry into skid.
    - ~acc & drn -> EMPTY.
  - State FULL (both valid):
    - drn -> ONE, skid moves to main.
    - else hold.
    - acc impossible in FULL.
- in_ready = (state != FULL), driven from a register; no combinational path from out_ready.
- out_valid = (state != EMPTY).
- Ordering is strictly FIFO; an entry is never duplicated or dropped except by flush/reset.
- Outputs are held stable while out_valid & ~out_ready.
- flush_in=1:
  - Next state EMPTY; same-cycle acc is discarded and any redirect it would cause is suppressed.
  - A drain in the same cycle still counts as delivered downstream.
- Reset (reset==0, overrides flush):
  - state EMPTY, out_valid=0, in_ready=1 after the edge, redirect_valid=0.
  - All data/control outputs 0: alu_result_out, store_data_out, rd_out, memtoreg_out, we_out, reg_en_out, redirect_target.
  - Reset mid-stall discards both entries.
- Latency: 1 cycle from acc to out_valid when EMPTY; throughput 1/cycle with out_ready held high.

Decomposition:
- Shared package riscv_pipe_pkg:
  - XLEN/REGW constants.
  - ALU op encodings (ALU_ADD=0, ALU_SUB=1).
  - ex_mem_t packed struct {alu_result, store_data, rd, memtoreg, we, reg_en}, reused by the MEM stage.
- Sub-module: skid_buffer, parameterised on payload width, carrying the ex_mem_t payload.
- ALU and branch comparator stay inline in ex_stage.

Test Plan:
- Reset (reset=0) with in_valid=1, data_in_1=5 -> after the edge out_valid=0, in_ready=1, all outputs 0, redirect_valid=0.
- Stream, out_ready=1:
  - data_in_1=7, imm_in=3, alusrc_in=1, aluop_in=0 -> next cycle alu_result_out=10.
  - data_in_1=7, data_in_2=9, alusrc_in=0, aluop_in=1 -> alu_result_out=0xFFFFFFFE.
- Branch: pcsrc_in=1, data_in_1=data_in_2=4, pc_in=0x100, imm_in=0xFFFFFFF0 -> redirect_valid pulses one cycle, redirect_target=0xF0. Same operands with data_in_2=5 -> no pulse.
- Backpressure:
  - out_ready=0, issue A, B, C -> A held on outputs, in_ready drops after B, C not accepted.
  - Raise out_ready -> A, B, C delivered in order, no gaps.
- Flush in FULL with simultaneous taken-branch acceptance -> next cycle out_valid=0, in_ready=1, no redirect pulse.
- Wrap: data_in_1=0xFFFFFFFF, imm_in=1, alusrc_in=1, aluop_in=0 -> alu_result_out=0. pc_in=0xFFFFFFFC, imm_in=8 on a taken branch -> redirect_target=4.
